// File: rtl/led_ws2812_decoder.sv
// rtl/led_ws2812_decoder.sv - WS2812 pin receiver: decodes GRB pixels, latch gaps and framing errors.
// Define LED_WS2812_DECODER_PASSTHROUGH_EN to regenerate the downstream pin after the first pixel.
module led_ws2812_decoder #(
    parameter int RESET_TICKS = 100,
    parameter int MAX_HIGH    = 3
) (
    input  logic       clk,
    input  logic       clk__enable,
    input  logic       reset,
    input  logic       led_data_pin,
    input  logic [7:0] divider_400ns,
    output logic       pixel__valid,
    output logic [7:0] pixel__led_number,
    output logic [7:0] pixel__red,
    output logic [7:0] pixel__green,
    output logic [7:0] pixel__blue,
    output logic       latch,
    output logic       bit_error,
    output logic       led_data_out_pin
);

    localparam int LOW_W = 16;

    typedef enum logic [1:0] {
        ST_RESYNC,
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_t;

    state_t      state_q;
    logic        sync1_q;
    logic        sync2_q;
    logic        s_prev_q;
    logic [7:0]  presc_q;
    logic [11:0] high_cnt_q;
    logic [LOW_W-1:0] low_ticks_q;
    logic [22:0] shift_q;
    logic [4:0]  bit_cnt_q;
    logic [7:0]  led_num_q;
    logic        valid_q;
    logic [7:0]  pix_led_q;
    logic [7:0]  red_q;
    logic [7:0]  green_q;
    logic [7:0]  blue_q;
    logic        latch_q;
    logic        err_q;

    logic        s;
    logic        rise;
    logic        fall;
    logic        tick;
    logic [7:0]  presc_d;
    logic [8:0]  t_cycles;
    logic [9:0]  thr;
    logic [11:0] max_high_cycles;
    logic        high_over;
    logic        bit_val;
    logic [23:0] shift_d;
    logic        low_done;
    logic [11:0] high_cnt_d;
    logic [7:0]  led_num_d;

    assign s    = sync2_q;
    assign rise = s & ~s_prev_q;
    assign fall = ~s & s_prev_q;
    assign tick = (presc_q == divider_400ns);

    always_comb begin
        presc_d = presc_q + 8'd1;
        if (rise || tick) begin
            presc_d = 8'd0;
        end
    end

    // Bit threshold is 1.5 ticks; the overlong limit is measured in cycles so it is phase independent.
    assign t_cycles        = {1'b0, divider_400ns} + 9'd1;
    assign thr             = {1'b0, t_cycles} + {2'b00, t_cycles[8:1]};
    assign max_high_cycles = 12'(MAX_HIGH) * {3'b000, t_cycles};
    assign high_over       = high_cnt_q > max_high_cycles;
    assign bit_val         = high_cnt_q > {2'b00, thr};
    assign shift_d         = {shift_q, bit_val};
    assign low_done        = tick && (low_ticks_q == LOW_W'(RESET_TICKS - 1));
    assign high_cnt_d      = (high_cnt_q == 12'hFFF) ? high_cnt_q : high_cnt_q + 12'd1;
    assign led_num_d       = (led_num_q == 8'hFF) ? led_num_q : led_num_q + 8'd1;

`ifdef LED_WS2812_DECODER_PASSTHROUGH_EN
    logic fwd_q;
    logic out_q;
    assign led_data_out_pin = out_q;
`else
    assign led_data_out_pin = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RESYNC;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            s_prev_q    <= 1'b0;
            presc_q     <= 8'd0;
            high_cnt_q  <= 12'd0;
            low_ticks_q <= '0;
            shift_q     <= 23'd0;
            bit_cnt_q   <= 5'd0;
            led_num_q   <= 8'd0;
            valid_q     <= 1'b0;
            pix_led_q   <= 8'd0;
            red_q       <= 8'd0;
            green_q     <= 8'd0;
            blue_q      <= 8'd0;
            latch_q     <= 1'b0;
            err_q       <= 1'b0;
`ifdef LED_WS2812_DECODER_PASSTHROUGH_EN
            fwd_q       <= 1'b0;
            out_q       <= 1'b0;
`endif
        end else if (!clk__enable) begin
            valid_q <= 1'b0;
            latch_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q  <= led_data_pin;
            sync2_q  <= sync1_q;
            s_prev_q <= sync2_q;
            presc_q  <= presc_d;
            valid_q  <= 1'b0;
            latch_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef LED_WS2812_DECODER_PASSTHROUGH_EN
            out_q    <= s & fwd_q;
`endif
            case (state_q)
                ST_RESYNC: begin
                    if (s) begin
                        low_ticks_q <= '0;
                    end else if (low_done) begin
                        low_ticks_q <= '0;
                        state_q     <= ST_IDLE;
                    end else if (tick) begin
                        low_ticks_q <= low_ticks_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (rise) begin
                        state_q    <= ST_HIGH;
                        bit_cnt_q  <= 5'd0;
                        led_num_q  <= 8'd0;
                        high_cnt_q <= 12'd1;
                    end
                end
                ST_HIGH: begin
                    // An overlong pulse beats a coincident falling edge.
                    if (high_over) begin
                        err_q       <= 1'b1;
                        low_ticks_q <= '0;
                        state_q     <= ST_RESYNC;
`ifdef LED_WS2812_DECODER_PASSTHROUGH_EN
                        fwd_q       <= 1'b0;
`endif
                    end else if (fall) begin
                        shift_q     <= shift_d[22:0];
                        low_ticks_q <= '0;
                        state_q     <= ST_LOW;
                        if (bit_cnt_q == 5'd23) begin
                            valid_q   <= 1'b1;
                            pix_led_q <= led_num_q;
                            green_q   <= shift_d[23:16];
                            red_q     <= shift_d[15:8];
                            blue_q    <= shift_d[7:0];
                            bit_cnt_q <= 5'd0;
                            led_num_q <= led_num_d;
`ifdef LED_WS2812_DECODER_PASSTHROUGH_EN
                            fwd_q     <= 1'b1;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end else begin
                        high_cnt_q <= high_cnt_d;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        state_q    <= ST_HIGH;
                        high_cnt_q <= 12'd1;
                    end else if (low_done) begin
                        latch_q   <= 1'b1;
                        err_q     <= (bit_cnt_q != 5'd0);
                        bit_cnt_q <= 5'd0;
                        state_q   <= ST_IDLE;
`ifdef LED_WS2812_DECODER_PASSTHROUGH_EN
                        fwd_q     <= 1'b0;
`endif
                    end else if (tick) begin
                        low_ticks_q <= low_ticks_q + 1'b1;
                    end
                end
                default: state_q <= ST_RESYNC;
            endcase
        end
    end

    assign pixel__valid      = valid_q;
    assign pixel__led_number = pix_led_q;
    assign pixel__red        = red_q;
    assign pixel__green      = green_q;
    assign pixel__blue       = blue_q;
    assign latch             = latch_q;
    assign bit_error         = err_q;

endmodule
